// File: rtl/ped_request_latch.sv
// ---------------------------------------------------------------------------
// ped_request_latch
//
// Turns a debounced pedestrian button level into press / long-press strobes
// and keeps a latched pedestrian request for the traffic controller. After
// the controller acknowledges a request, new presses are still classified,
// but they are not latched until a holdoff window has expired.
//
// Parameters
//   LONG_CYCLES    : held cycles that classify a press as long (2..2^32-1)
//   HOLDOFF_CYCLES : cycles after an acknowledge during which presses are
//                    not latched (0 disables the holdoff)
//
// Ports
//   clk          in  system clock, rising-edge active
//   rst_n        in  asynchronous active-low reset
//   btn_level    in  debounced, clk-synchronous button level (1 = pressed)
//   req_ack      in  one-cycle acknowledge from the traffic controller
//   press_pulse  out one-cycle strobe per detected press
//   long_pulse   out one-cycle strobe when a press reaches LONG_CYCLES
//   req_pending  out latched pedestrian request
//   req_priority out pending request is a long-press priority request
//   holdoff      out post-acknowledge holdoff window is running
// ---------------------------------------------------------------------------
module ped_request_latch #(
    parameter int unsigned LONG_CYCLES    = 32'd150_000_000,
    parameter int unsigned HOLDOFF_CYCLES = 32'd50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_level,
    input  logic req_ack,
    output logic press_pulse,
    output logic long_pulse,
    output logic req_pending,
    output logic req_priority,
    output logic holdoff
);

    // Last count value before a press becomes long; the counter saturates here.
    localparam logic [31:0] LONG_LAST    = 32'(LONG_CYCLES - 32'd1);
    localparam logic [31:0] HOLDOFF_LOAD = 32'(HOLDOFF_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESSED   = 2'd1,
        ST_LONG_HELD = 2'd2
    } state_t;

    state_t      state_q,       state_d;
    logic [31:0] hold_cnt_q,    hold_cnt_d;
    logic [31:0] holdoff_cnt_q, holdoff_cnt_d;
    logic        prev_level_q;
    logic        press_pulse_q, press_pulse_d;
    logic        long_pulse_q,  long_pulse_d;
    logic        req_pending_q, req_pending_d;
    logic        req_prio_q,    req_prio_d;
    logic        holdoff_q,     holdoff_d;
    logic        ack_take_s;

    // Press classification: edge detect, hold counting, long-press detection.
    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        press_pulse_d = 1'b0;
        long_pulse_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (btn_level && !prev_level_q) begin
                    state_d       = ST_PRESSED;
                    hold_cnt_d    = 32'd0;
                    press_pulse_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRESSED: begin
                if (!btn_level) begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = 32'd0;
                end else if (hold_cnt_q == LONG_LAST) begin
                    // Counter stays at LONG_LAST; it never wraps.
                    state_d      = ST_LONG_HELD;
                    long_pulse_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 32'd1;
                end
            end
            ST_LONG_HELD: begin
                if (!btn_level) begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = 32'd0;
                end else begin
                    state_d = ST_LONG_HELD;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                hold_cnt_d = 32'd0;
            end
        endcase
    end

    // Request latch and holdoff window; an acknowledge outranks a coincident press.
    always_comb begin
        ack_take_s    = req_ack && req_pending_q;
        req_pending_d = req_pending_q;
        holdoff_cnt_d = holdoff_cnt_q;
        if (ack_take_s) begin
            req_pending_d = 1'b0;
            holdoff_cnt_d = HOLDOFF_LOAD;
        end else begin
            if (press_pulse_d && !holdoff_q) begin
                req_pending_d = 1'b1;
            end else begin
                req_pending_d = req_pending_q;
            end
            if (holdoff_cnt_q != 32'd0) begin
                holdoff_cnt_d = holdoff_cnt_q - 32'd1;
            end else begin
                holdoff_cnt_d = 32'd0;
            end
        end
        // Priority survives only while the request stays pending.
        req_prio_d = req_pending_d && (req_prio_q || long_pulse_d);
        holdoff_d  = (holdoff_cnt_d != 32'd0);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            hold_cnt_q    <= 32'd0;
            holdoff_cnt_q <= 32'd0;
            // Reset to 1 so a button held through reset is not seen as a press.
            prev_level_q  <= 1'b1;
            press_pulse_q <= 1'b0;
            long_pulse_q  <= 1'b0;
            req_pending_q <= 1'b0;
            req_prio_q    <= 1'b0;
            holdoff_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            holdoff_cnt_q <= holdoff_cnt_d;
            prev_level_q  <= btn_level;
            press_pulse_q <= press_pulse_d;
            long_pulse_q  <= long_pulse_d;
            req_pending_q <= req_pending_d;
            req_prio_q    <= req_prio_d;
            holdoff_q     <= holdoff_d;
        end
    end

    assign press_pulse  = press_pulse_q;
    assign long_pulse   = long_pulse_q;
    assign req_pending  = req_pending_q;
    assign req_priority = req_prio_q;
    assign holdoff      = holdoff_q;

endmodule
